// File: rtl/washing_machine_seq_ctrl.sv
// Washing-machine sequencer: fill/detergent/wash/drain/rinse/spin with sensor watchdogs, pause, abort-drain and fault codes.
// Optional pre-wash stage (PRE_FILL/PRE_WASH/PRE_DRAIN) is enabled by defining WM_PREWASH_EN.
module washing_machine_seq_ctrl #(
    parameter int RINSE_CYCLES  = 2,
    parameter int WASH_TICKS    = 1000,
    parameter int RINSE_TICKS   = 500,
    parameter int SPIN_TICKS    = 800,
    parameter int PREWASH_TICKS = 300,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       door_closed,
    input  logic       level_full,
    input  logic       level_empty,
    input  logic       detergent_added,
    input  logic       pause,
    input  logic       abort,
    input  logic       clear_fault,
    output logic       fill_valve_on,
    output logic       detergent_valve_on,
    output logic       motor_on,
    output logic       drain_valve_on,
    output logic       spin_motor_on,
    output logic       door_lock,
    output logic       done,
    output logic       busy,
    output logic [2:0] fault_code,
    output logic [3:0] phase,
    output logic [2:0] rinse_count
);

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_PRE_FILL      = 4'd1,
        ST_PRE_WASH      = 4'd2,
        ST_PRE_DRAIN     = 4'd3,
        ST_FILL          = 4'd4,
        ST_DETERGENT     = 4'd5,
        ST_WASH          = 4'd6,
        ST_DRAIN         = 4'd7,
        ST_RINSE_FILL    = 4'd8,
        ST_RINSE_AGITATE = 4'd9,
        ST_RINSE_DRAIN   = 4'd10,
        ST_SPIN          = 4'd11,
        ST_DONE          = 4'd12,
        ST_ABORT_DRAIN   = 4'd13,
        ST_FAULT         = 4'd14
    } state_t;

    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREWASH_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [2:0]       RINSE_TGT  = 3'(RINSE_CYCLES);

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_FILL  = 3'd1;
    localparam logic [2:0] FC_DRAIN = 3'd2;
    localparam logic [2:0] FC_DET   = 3'd3;
    localparam logic [2:0] FC_DOOR  = 3'd4;

`ifdef WM_PREWASH_EN
    localparam state_t LAUNCH_ST = ST_PRE_FILL;
`else
    localparam state_t LAUNCH_ST = ST_FILL;
`endif

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       rinse_r;
    logic [2:0]       fault_r;
    logic [2:0]       fault_s;
    logic             rinse_inc_s;
    logic             wd_s;
    logic             busy_s;
    logic             run_state_s;
    logic             act_en_s;
    logic             cnt_en_s;
    logic             fill_s;
    logic             det_s;
    logic             motor_s;
    logic             drain_s;
    logic             spin_s;
    logic             door_s;

    assign wd_s        = (cnt_r == TO_LAST);
    assign busy_s      = (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_FAULT);
    assign run_state_s = (state_r >= ST_PRE_FILL) && (state_r <= ST_SPIN);
    assign act_en_s    = !(pause && run_state_s);
    // ABORT_DRAIN keeps its watchdog running even while pause is held
    assign cnt_en_s    = busy_s && (!pause || (state_r == ST_ABORT_DRAIN));

    // Next-state selection, fault code capture and rinse advance
    always_comb begin
        state_s     = state_r;
        fault_s     = fault_r;
        rinse_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && door_closed) state_s = LAUNCH_ST;
                else                      state_s = ST_IDLE;
            end
            ST_DONE: begin
                if (!start) state_s = ST_IDLE;
                else        state_s = ST_DONE;
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_s = ST_IDLE;
                    fault_s = FC_NONE;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                if (!door_closed) begin
                    state_s = ST_FAULT;
                    fault_s = FC_DOOR;
                end else if (abort && (state_r != ST_ABORT_DRAIN)) begin
                    state_s = ST_ABORT_DRAIN;
                end else if (pause && (state_r != ST_ABORT_DRAIN)) begin
                    state_s = state_r;
                end else begin
                    case (state_r)
                        ST_PRE_FILL, ST_FILL, ST_RINSE_FILL: begin
                            if (level_full) begin
                                if (state_r == ST_PRE_FILL)  state_s = ST_PRE_WASH;
                                else if (state_r == ST_FILL) state_s = ST_DETERGENT;
                                else                         state_s = ST_RINSE_AGITATE;
                            end else if (wd_s) begin
                                state_s = ST_FAULT;
                                fault_s = FC_FILL;
                            end else begin
                                state_s = state_r;
                            end
                        end
                        ST_DETERGENT: begin
                            if (detergent_added) begin
                                state_s = ST_WASH;
                            end else if (wd_s) begin
                                state_s = ST_FAULT;
                                fault_s = FC_DET;
                            end else begin
                                state_s = state_r;
                            end
                        end
                        ST_PRE_DRAIN, ST_DRAIN, ST_RINSE_DRAIN, ST_ABORT_DRAIN: begin
                            if (level_empty) begin
                                if (state_r == ST_PRE_DRAIN) begin
                                    state_s = ST_FILL;
                                end else if (state_r == ST_ABORT_DRAIN) begin
                                    state_s = ST_IDLE;
                                end else if (state_r == ST_DRAIN) begin
                                    state_s = (RINSE_TGT == 3'd0) ? ST_SPIN : ST_RINSE_FILL;
                                end else begin
                                    rinse_inc_s = 1'b1;
                                    state_s = ((rinse_r + 3'd1) == RINSE_TGT) ? ST_SPIN : ST_RINSE_FILL;
                                end
                            end else if (wd_s) begin
                                state_s = ST_FAULT;
                                fault_s = FC_DRAIN;
                            end else begin
                                state_s = state_r;
                            end
                        end
                        ST_PRE_WASH: begin
                            if (cnt_r == PRE_LAST) state_s = ST_PRE_DRAIN;
                            else                   state_s = state_r;
                        end
                        ST_WASH: begin
                            if (cnt_r == WASH_LAST) state_s = ST_DRAIN;
                            else                    state_s = state_r;
                        end
                        ST_RINSE_AGITATE: begin
                            if (cnt_r == RINSE_LAST) state_s = ST_RINSE_DRAIN;
                            else                     state_s = state_r;
                        end
                        ST_SPIN: begin
                            if (cnt_r == SPIN_LAST) state_s = ST_DONE;
                            else                    state_s = state_r;
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // State register, phase/watchdog counter, rinse tally and latched fault code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            rinse_r <= 3'd0;
            fault_r <= FC_NONE;
        end else begin
            state_r <= state_s;
            fault_r <= fault_s;
            if (state_s != state_r) cnt_r <= '0;
            else if (cnt_en_s)      cnt_r <= cnt_r + CNT_W'(1);
            else                    cnt_r <= cnt_r;
            if ((state_r == ST_IDLE) && (state_s != ST_IDLE)) rinse_r <= 3'd0;
            else if (rinse_inc_s)                             rinse_r <= rinse_r + 3'd1;
            else                                              rinse_r <= rinse_r;
        end
    end

    // Moore actuator decode of the registered state
    always_comb begin
        fill_s  = 1'b0;
        det_s   = 1'b0;
        motor_s = 1'b0;
        drain_s = 1'b0;
        spin_s  = 1'b0;
        case (state_r)
            ST_PRE_FILL, ST_FILL, ST_RINSE_FILL:                    fill_s  = 1'b1;
            ST_DETERGENT:                                           det_s   = 1'b1;
            ST_PRE_WASH, ST_WASH, ST_RINSE_AGITATE:                 motor_s = 1'b1;
            ST_PRE_DRAIN, ST_DRAIN, ST_RINSE_DRAIN, ST_ABORT_DRAIN: drain_s = 1'b1;
            ST_SPIN: begin
                drain_s = 1'b1;
                spin_s  = 1'b1;
            end
            default: fill_s = 1'b0;
        endcase
        // In FAULT the latch holds only while water is still in the drum
        if (run_state_s || (state_r == ST_ABORT_DRAIN)) door_s = 1'b1;
        else if (state_r == ST_FAULT)                   door_s = ~level_empty;
        else                                            door_s = 1'b0;
    end

    assign fill_valve_on      = fill_s  & act_en_s;
    assign detergent_valve_on = det_s   & act_en_s;
    assign motor_on           = motor_s & act_en_s;
    assign drain_valve_on     = drain_s & act_en_s;
    assign spin_motor_on      = spin_s  & act_en_s;
    assign door_lock          = door_s;
    assign done               = (state_r == ST_DONE);
    assign busy               = busy_s;
    assign fault_code         = fault_r;
    assign phase              = state_r;
    assign rinse_count        = rinse_r;

endmodule
